// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-stage bundle (control in, instruction memory port, IF/ID handshake to decode)
interface pc_fetch_unit_if;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic [15:0] IAddress;
  logic        InsMemRW;
  logic [3:0]  op_in, rs_in, rt_in, imm_in;
  logic [3:0]  op, rs, rt, imm;
  logic [15:0] IF_PC;
  logic        IValid;
  logic        DReady;
  logic        Halted;
  modport master (
    input  Stall, BranchTaken, BranchTarget, op_in, rs_in, rt_in, imm_in, DReady,
    output IAddress, InsMemRW, op, rs, rt, imm, IF_PC, IValid, Halted
  );
  modport slave (
    output Stall, BranchTaken, BranchTarget, op_in, rs_in, rt_in, imm_in, DReady,
    input  IAddress, InsMemRW, op, rs, rt, imm, IF_PC, IValid, Halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner, IF/ID capture register with valid/ready handoff, branch flush and stall.
// Defining HALT_OP_EN stops fetching after capturing HALT_OP.
module pc_fetch_unit #(
  parameter int          IMEM_DEPTH = 32,
  parameter logic [15:0] RESET_PC   = 16'h0000
`ifdef HALT_OP_EN
  , parameter logic [3:0] HALT_OP   = 4'b1111
`endif
) (
  input logic             CLK,
  input logic             RST_n,
  pc_fetch_unit_if.master bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] pc, if_pc;
  logic [15:0] ir;
  logic valid, branch, advance, consume;
  logic unused_target;
  assign unused_target = ^bus.BranchTarget[15:AW];
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    branch    = state == FETCH && bus.BranchTaken;
    advance   = state == FETCH && !bus.Stall && (!valid || bus.DReady);
    consume   = valid && bus.DReady;
    state_nxt = state == IDLE ? FETCH : state;
`ifdef HALT_OP_EN
    if (advance && !branch && bus.op_in == HALT_OP) state_nxt = HALT;
`endif
  end
  // Branch beats capture; capture beats a plain decode handoff.
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      pc    <= RESET_PC[AW-1:0];
      if_pc <= '0;
      ir    <= '0;
      valid <= 1'b0;
    end else if (branch) begin
      pc    <= bus.BranchTarget[AW-1:0];
      valid <= 1'b0;
    end else if (advance) begin
      ir    <= {bus.op_in, bus.rs_in, bus.rt_in, bus.imm_in};
      if_pc <= pc;
      valid <= 1'b1;
      pc    <= pc + AW'(1);
    end else if (consume) begin
      valid <= 1'b0;
    end
  assign bus.IAddress = 16'(pc);
  assign bus.InsMemRW = 1'b0;
  assign {bus.op, bus.rs, bus.rt, bus.imm} = ir;
  assign bus.IF_PC  = 16'(if_pc);
  assign bus.IValid = valid;
`ifdef HALT_OP_EN
  assign bus.Halted = state == HALT;
`else
  assign bus.Halted = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table plus hand-written wrap, reset and halt sequences.
module tb_pc_fetch_unit;
  logic CLK, RST_n;
  logic [15:0] mem [32];
  int checks = 0, errors = 0;
  pc_fetch_unit_if bus();
  pc_fetch_unit dut (.CLK(CLK), .RST_n(RST_n), .bus(bus));
  assign {bus.op_in, bus.rs_in, bus.rt_in, bus.imm_in} = mem[bus.IAddress[4:0]];
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        dr;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] ifpc;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic s, logic b, logic [15:0] t, logic d, logic [15:0] a, logic v, logic [15:0] p);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.dr = d; r.addr = a; r.valid = v; r.ifpc = p;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic s, input logic b, input logic [15:0] t, input logic d);
    bus.Stall = s; bus.BranchTaken = b; bus.BranchTarget = t; bus.DReady = d;
  endtask
  task automatic chk_state(input string nm, input logic [15:0] a, input logic v, input logic [15:0] p);
    chk({nm, " IAddress"}, 32'(bus.IAddress), 32'(a));
    chk({nm, " IValid"}, 32'(bus.IValid), 32'(v));
    chk({nm, " IF_PC"}, 32'(bus.IF_PC), 32'(p));
    if (v) chk({nm, " IR"}, 32'({bus.op, bus.rs, bus.rt, bus.imm}), 32'(mem[p[4:0]]));
  endtask
  initial begin
    logic [15:0] ea, ei;
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i) * 16'h0011;
    vecs.push_back(mk(0, 0, 16'h0000, 1,  0, 0,  0));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  1, 1,  0));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  2, 1,  1));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  3, 1,  2));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  4, 1,  3));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  5, 1,  4));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 16'h0000, 0, 5, 1, 4));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  6, 1,  5));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  7, 1,  6));
    vecs.push_back(mk(0, 1, 16'h0025, 1,  5, 0,  6));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  6, 1,  5));
    vecs.push_back(mk(1, 0, 16'h0000, 1,  6, 0,  5));
    vecs.push_back(mk(1, 0, 16'h0000, 1,  6, 0,  5));
    vecs.push_back(mk(1, 0, 16'h0000, 1,  6, 0,  5));
    vecs.push_back(mk(1, 1, 16'h0009, 1,  9, 0,  5));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 10, 1,  9));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 10, 1,  9));
    vecs.push_back(mk(0, 1, 16'hFFFF, 0, 31, 0,  9));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  0, 1, 31));
    vecs.push_back(mk(0, 0, 16'h0000, 1,  1, 1,  0));
    drive(0, 0, 16'h0000, 1);
    RST_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_state("reset", 0, 0, 0);
    chk("reset IR", 32'({bus.op, bus.rs, bus.rt, bus.imm}), 0);
    chk("reset Halted", 32'(bus.Halted), 0);
    chk("reset InsMemRW", 32'(bus.InsMemRW), 0);
    RST_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].dr);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].ifpc);
      chk($sformatf("vec%0d Halted", i), 32'(bus.Halted), 0);
      chk($sformatf("vec%0d InsMemRW", i), 32'(bus.InsMemRW), 0);
    end
    drive(0, 0, 16'h0000, 1);
    ea = 16'd1;
    for (int i = 0; i < 34; i++) begin
      ei = ea;
      ea = (ea + 16'd1) % 16'd32;
      step();
      chk_state($sformatf("run%0d", i), ea, 1, ei);
    end
    @(posedge CLK);
    #3;
    RST_n = 1'b0;
    #1;
    chk_state("async reset", 0, 0, 0);
    chk("async reset IR", 32'({bus.op, bus.rs, bus.rt, bus.imm}), 0);
    drive(0, 1, 16'h0007, 1);
    step();
    RST_n = 1'b1;
    step();
    chk_state("idle branch ignored", 0, 0, 0);
    drive(0, 0, 16'h0000, 1);
    step();
    chk_state("after idle", 1, 1, 0);
`ifdef HALT_OP_EN
    mem[3] = 16'hF123;
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_state($sformatf("pre-halt%0d", i), 16'(i), 1, 16'(i - 1));
    end
    chk("halt Halted", 32'(bus.Halted), 1);
    chk("halt op", 32'(bus.op), 32'hF);
    drive(0, 0, 16'h0000, 0);
    repeat (2) begin
      step();
      chk_state("halt held", 4, 1, 3);
    end
    drive(0, 0, 16'h0000, 1);
    step();
    chk_state("halt consumed", 4, 0, 3);
    drive(0, 1, 16'h0009, 1);
    step();
    chk_state("halt branch ignored", 4, 0, 3);
    chk("halt sticky", 32'(bus.Halted), 1);
    drive(0, 0, 16'h0000, 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("halt reset IAddress", 32'(bus.IAddress), 0);
    chk("halt reset Halted", 32'(bus.Halted), 0);
    RST_n = 1'b1;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
